wb_ram_slave: RTL and testbench



---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_ram_array.sv | 23 ++
 rtl/wb_ram_slave.sv | 110 +++++++++++
 tb/tb_wb_ram_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, responder FSM states and the latched request record.
package wb_pkg;
  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_slv_state_t;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_req_t;
endpackage

// File: rtl/wb_ram_array.sv
// Byte-lane write, registered-read single-port RAM; one-cycle read latency, no backpressure.
// A same-index read during a write returns the previous contents.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WB_SEL_W-1:0]   sel,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WB_DAT_W-1:0]   wdata,
  output logic [WB_DAT_W-1:0]   rdata
);
  logic [WB_DAT_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (we && sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end
endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM responder: ack 1+WAIT_STATES cycles after the request is sampled.
// No backpressure beyond wait states; dropping cyc/stb during WAIT aborts the transfer silently.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int                  DEPTH_LOG2  = 10,
  parameter logic [WB_ADR_W-1:0] BASE_ADR    = 30'h0,
  parameter int                  WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] adr_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic                ack_o
);
  wb_slv_state_t       state;
  logic [3:0]          wait_cnt;
  wb_req_t             req_q;
  wb_req_t             cur;
  logic                req;
  logic                enter_ack;
  logic                hit;
  logic                hit_q;
  logic                commit;
  logic [WB_ADR_W-1:0] ofs;
  logic [WB_DAT_W-1:0] ram_rdata;
  logic [WB_DAT_W-1:0] rd_word;
  logic [WB_DAT_W-1:0] hold_q;

  assign req = cyc_i & stb_i;

  // With no wait states the sampling edge is also the edge entering ACK, so decode live inputs in IDLE.
  always_comb begin
    cur = req_q;
    if (state == IDLE) cur = {adr_i, dat_i, sel_i, we_i};
  end

  // Unsigned wrap makes addresses below BASE_ADR land far out of range.
  assign ofs = cur.adr - BASE_ADR;
  assign hit = (ofs >> DEPTH_LOG2) == '0;

  always_comb begin
    enter_ack = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE:    enter_ack = req && (WAIT_STATES == 0);
        WAIT:    enter_ack = req && (wait_cnt == 4'd0);
        default: enter_ack = 1'b0;
      endcase
    end
  end

  assign commit = enter_ack & cur.we & hit;

  wb_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk_i),
    .we   (commit),
    .sel  (cur.sel),
    .idx  (ofs[DEPTH_LOG2-1:0]),
    .wdata(cur.dat),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ack_o    <= 1'b0;
      hit_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      ack_o <= enter_ack;
      if (enter_ack) hit_q <= hit;
      case (state)
        IDLE: begin
          if (req) begin
            req_q <= cur;
            if (WAIT_STATES == 0) begin
              state <= ACK;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!req)                  state    <= IDLE;
          else if (wait_cnt == 4'd0) state    <= ACK;
          else                       wait_cnt <= wait_cnt - 4'd1;
        end
        ACK: begin
          state <= IDLE;
          if (!req_q.we) hold_q <= rd_word;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM output is live during the read's ACK cycle, then held until the next read completes.
  assign rd_word = hit_q ? ram_rdata : '0;
  assign dat_o   = (state == ACK && !req_q.we) ? rd_word : hold_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances cover zero-wait, 3-wait and offset-base decode,
// with a per-instance scoreboard of expected dat_o values popped on every ack.
module tb_wb_ram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cyc = '0;
  logic [2:0]  ack;
  logic [31:0] rdo [3];

  int n_chk = 0;
  int n_err = 0;

  int ws_p   [3] = '{0, 3, 0};
  int base_p [3] = '{0, 0, 'h100};
  int dep_p  [3] = '{1024, 1024, 16};

  logic [31:0] mdl [logic [31:0]];
  logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  always #5 clk = ~clk;

  wb_ram_slave #(.DEPTH_LOG2(10), .BASE_ADR(30'h0), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc[0]), .stb_i(stb), .dat_o(rdo[0]), .ack_o(ack[0]));
  wb_ram_slave #(.DEPTH_LOG2(10), .BASE_ADR(30'h0), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc[1]), .stb_i(stb), .dat_o(rdo[1]), .ack_o(ack[1]));
  wb_ram_slave #(.DEPTH_LOG2(4), .BASE_ADR(30'h100), .WAIT_STATES(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc[2]), .stb_i(stb), .dat_o(rdo[2]), .ack_o(ack[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int d, input logic [31:0] e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int d, input logic [31:0] act);
    logic [31:0] e;
    int n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      chk($sformatf("ack_unexp%0d", d), {31'b0, ack[d]}, 32'h0);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("dat_o%0d", d), act, e);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d]) sb_pop(d, rdo[d]);
    end
  end

  // Predict the outcome from an address-keyed memory model and queue it.
  task automatic model_xfer(input int d, input logic w, input logic [29:0] a,
                            input logic [31:0] dt, input logic [3:0] s);
    int          off;
    logic        hitm;
    logic [31:0] key;
    logic [31:0] e;
    off  = int'(a) - base_p[d];
    hitm = (off >= 0) && (off < dep_p[d]);
    key  = {d[1:0], a};
    if (w) begin
      if (hitm) begin
        e = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) e[8*i +: 8] = dt[8*i +: 8];
        mdl[key] = e;
      end
      sb_push(d, last_rd[d]);
    end else begin
      e = (hitm && mdl.exists(key)) ? mdl[key] : 32'h0;
      last_rd[d] = e;
      sb_push(d, e);
    end
  endtask

  task automatic drive(input int d, input logic w, input logic [29:0] a,
                       input logic [31:0] dt, input logic [3:0] s);
    @(posedge clk); #1;
    adr = a; wdat = dt; sel = s; we = w; stb = 1'b1; cyc[d] = 1'b1;
  endtask

  task automatic xfer(input int d, input logic w, input logic [29:0] a,
                      input logic [31:0] dt, input logic [3:0] s);
    int got;
    model_xfer(d, w, a, dt, s);
    drive(d, w, a, dt, s);
    @(posedge clk);
    got = -1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = k;
        break;
      end
    end
    chk($sformatf("ack_lat%0d", d), got, ws_p[d]);
    @(posedge clk); #1;
    stb = 1'b0; cyc = '0;
    @(negedge clk);
    chk($sformatf("ack_width%0d", d), {31'b0, ack[d]}, 32'h0);
  endtask

  // Start a transfer, then kill it one cycle into WAIT either by dropping stb or by reset.
  task automatic abort_xfer(input int d, input logic w, input logic [29:0] a,
                            input logic [31:0] dt, input logic [3:0] s, input bit rst_mid);
    int n;
    drive(d, w, a, dt, s);
    @(posedge clk);
    @(posedge clk); #1;
    if (rst_mid) rst = 1'b1;
    else begin
      stb = 1'b0; cyc = '0;
    end
    @(posedge clk); #1;
    rst = 1'b0; stb = 1'b0; cyc = '0;
    if (rst_mid) last_rd = '{32'h0, 32'h0, 32'h0};
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[d]) n++;
    end
    chk(rst_mid ? "rst_mid_noack" : "abort_noack", n, 0);
    chk(rst_mid ? "rst_mid_dat" : "abort_dat", rdo[d], last_rd[d]);
  endtask

  initial begin
    int n;
    logic [7:0] pat;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(ack[0]) + int'(ack[1]) + int'(ack[2]);
    end
    chk("rst_ack", n, 0);
    for (int d = 0; d < 3; d++) chk($sformatf("rst_dat%0d", d), rdo[d], 32'h0);

    xfer(0, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 30'd5, 32'h0, 4'hF);
    xfer(0, 1'b1, 30'd5, 32'h11223344, 4'b0101);
    xfer(0, 1'b0, 30'd5, 32'h0, 4'hF);
    xfer(0, 1'b1, 30'd5, 32'hFFFFFFFF, 4'b0000);
    xfer(0, 1'b0, 30'd5, 32'h0, 4'b0001);
    chk("lane_merge", last_rd[0], 32'hDE22BE44);

    for (int i = 0; i < 4; i++) model_xfer(0, 1'b0, 30'd5, 32'h0, 4'hF);
    drive(0, 1'b0, 30'd5, 32'h0, 4'hF);
    pat = '0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      pat = {pat[6:0], ack[0]};
    end
    stb = 1'b0; cyc = '0;
    chk("held_pat", {24'h0, pat}, 32'h000000AA);
    repeat (2) @(negedge clk);

    xfer(1, 1'b1, 30'd9, 32'hCAFEF00D, 4'hF);
    xfer(1, 1'b0, 30'd9, 32'h0, 4'hF);
    abort_xfer(1, 1'b0, 30'd9, 32'h0, 4'hF, 1'b0);
    abort_xfer(1, 1'b1, 30'd9, 32'h0BADBAD0, 4'hF, 1'b0);
    xfer(1, 1'b0, 30'd9, 32'h0, 4'hF);
    abort_xfer(1, 1'b1, 30'd9, 32'h12345678, 4'hF, 1'b1);
    xfer(1, 1'b0, 30'd9, 32'h0, 4'hF);

    xfer(2, 1'b1, 30'h100, 32'hA0A0A0A0, 4'hF);
    xfer(2, 1'b1, 30'h10F, 32'hB1B1B1B1, 4'hF);
    xfer(2, 1'b1, 30'h0FF, 32'h5A5A5A5A, 4'hF);
    xfer(2, 1'b1, 30'h110, 32'hC3C3C3C3, 4'hF);
    xfer(2, 1'b0, 30'h100, 32'h0, 4'hF);
    xfer(2, 1'b0, 30'h10F, 32'h0, 4'hF);
    xfer(2, 1'b0, 30'h0FF, 32'h0, 4'hF);
    xfer(2, 1'b0, 30'h110, 32'h0, 4'hF);

    repeat (4) @(negedge clk);
    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    chk("sb_left2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
